// File: rtl/fc_argmax_classifier.sv
// Streaming argmax over the N_CLASSES signed logits that FC2 left in its output BRAM.
// Latency: done rises N_CLASSES+RD_LAT+1 cycles after the edge that samples start.
// Backpressure: none; the BRAM is read at one word per cycle, and the start/done level handshake paces runs.
module fc_argmax_classifier #(
    parameter int N_CLASSES = 6,
    parameter int DATA_W    = 16,
    parameter int ADDR_W    = 4,
    parameter int RD_LAT    = 2,
    parameter int CLS_W     = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    output logic              done,
    output logic              mem_en,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_dout,
    output logic [CLS_W-1:0]  class_id,
    output logic [DATA_W-1:0] max_val,
    output logic              result_valid
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic [ADDR_W-1:0]        LAST_IDX = ADDR_W'(N_CLASSES - 1);
    localparam logic signed [DATA_W-1:0] MIN_VAL  = {1'b1, {(DATA_W-1){1'b0}}};

    state_t state;
    state_t state_nxt;

    logic [ADDR_W-1:0]        cnt;
    logic [RD_LAT-1:0]        vld_pipe;
    logic [ADDR_W-1:0]        idx_pipe [RD_LAT];
    logic signed [DATA_W-1:0] best_val;
    logic [ADDR_W-1:0]        best_idx;

    logic                     consume;
    logic [ADDR_W-1:0]        consume_idx;
    logic                     last_issue;
    logic                     last_consume;
    logic                     take;
    logic signed [DATA_W-1:0] cand_val;
    logic [ADDR_W-1:0]        cand_idx;

    // A word is consumed only when an issued read reaches the end of the valid pipe.
    assign consume      = vld_pipe[RD_LAT-1];
    assign consume_idx  = idx_pipe[RD_LAT-1];
    assign last_issue   = (cnt == LAST_IDX);
    assign last_consume = consume && (consume_idx == LAST_IDX);

    // Running best after folding in the word arriving this cycle; strict compare keeps the lower index on ties.
    always_comb begin
        take     = 1'b0;
        cand_val = best_val;
        cand_idx = best_idx;
        if (consume && ($signed(mem_dout) > best_val)) begin
            take     = 1'b1;
            cand_val = $signed(mem_dout);
            cand_idx = consume_idx;
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic and state-decoded outputs.
    always_comb begin
        state_nxt = state;
        done      = 1'b0;
        mem_en    = 1'b0;
        mem_addr  = '0;
        unique case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = ISSUE;
                end
            end
            ISSUE: begin
                mem_en   = 1'b1;
                mem_addr = cnt;
                if (last_issue) begin
                    state_nxt = DRAIN;
                end
            end
            DRAIN: begin
                if (last_consume) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                done = 1'b1;
                if (!start) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Issue-valid and index tracking, aligned with the BRAM read latency.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            vld_pipe <= '0;
            for (int i = 0; i < RD_LAT; i++) begin
                idx_pipe[i] <= '0;
            end
        end else begin
            vld_pipe[0] <= mem_en;
            idx_pipe[0] <= cnt;
            for (int i = 1; i < RD_LAT; i++) begin
                vld_pipe[i] <= vld_pipe[i-1];
                idx_pipe[i] <= idx_pipe[i-1];
            end
        end
    end

    // Address counter, running best, and the published result.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt          <= '0;
            best_val     <= MIN_VAL;
            best_idx     <= '0;
            class_id     <= '0;
            max_val      <= '0;
            result_valid <= 1'b0;
        end else begin
            if (take) begin
                best_val <= cand_val;
                best_idx <= cand_idx;
            end
            unique case (state)
                IDLE: begin
                    if (start) begin
                        cnt          <= '0;
                        best_val     <= MIN_VAL;
                        best_idx     <= '0;
                        result_valid <= 1'b0;
                    end
                end
                ISSUE: begin
                    // Counter saturates at the last index so the address never wraps.
                    if (!last_issue) begin
                        cnt <= cnt + 1'b1;
                    end
                end
                DRAIN: begin
                    if (last_consume) begin
                        class_id     <= CLS_W'(cand_idx);
                        max_val      <= cand_val;
                        result_valid <= 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: doc/fc_argmax_classifier.md
Name: fc_argmax_classifier

Overview:
Final stage of the gesture CNN, directly downstream of the FC2 layer. After the layer sequencer starts it, the block reads the N_CLASSES signed logits that FC2 wrote into its output BRAM. It performs a streaming argmax and reports the winning gesture class index and its logit. It uses the same level start / level done handshake as every other layer in the chain.

Parameters:
N_CLASSES, 6, number of logits and gesture classes (1..2**ADDR_W).
DATA_W, 16, logit width, two's-complement signed.
ADDR_W, 4, BRAM address width.
RD_LAT, 2, BRAM read latency in cycles from mem_en/mem_addr to valid mem_dout (1..4).
CLS_W, 4, width of class_id.

Ports:
clk  in  1  system clock.
rst_n  in  1  synchronous active-low reset.
start  in  1  level request from layer sequencer, sampled in IDLE.
done  out  1  high in DONE state.
mem_en  out  1  BRAM port-B read enable.
mem_addr  out  ADDR_W  BRAM read address.
mem_dout  in  DATA_W  BRAM read data, valid RD_LAT cycles after the address.
class_id  out  CLS_W  index of max logit.
max_val  out  DATA_W  value of max logit.
result_valid  out  1  class_id/max_val hold a completed result.

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous, active-low on rst_n, sampled at posedge clk.
- Reset values: state=IDLE; done=0, mem_en=0, mem_addr=0, class_id=0, max_val=0, result_valid=0; valid pipe cleared.
- Reset mid-run: aborts at the next edge with the same reset values. No partial result is kept.
- States: IDLE, ISSUE, DRAIN, DONE.
- IDLE: if start=1 at edge T, go to ISSUE. Clear result_valid, set best_val to the most negative value (-2**(DATA_W-1)), best_idx=0, addr counter=0.
- ISSUE: mem_en=1, mem_addr=counter. Addr k is driven in cycle T+1+k. After addr N_CLASSES-1 is driven, go to DRAIN. No wrap: the counter never exceeds N_CLASSES-1.
- Valid tracking: an RD_LAT-deep shift register of issue-valid bits and issued indices. Data for index k is consumed at the end of cycle T+1+k+RD_LAT.
- Compare rule: on a consumed word d with index k, if d > best_val (signed, strict), set best_val=d and best_idx=k.
  - Ties keep the lower index.
  - The first word always replaces the initial sentinel unless it equals the sentinel. In that case best_idx stays 0, which is still correct.
- DRAIN: mem_en=0. Wait until the last index is consumed, then go to DONE. At that edge, class_id=best_idx, max_val=best_val, result_valid=1.
- DONE: done=1. Stay while start=1. When start=0, go to IDLE, with done low from the next cycle.
  - class_id, max_val and result_valid hold until the next accepted start or reset.
- Latency: done first high in cycle T+N_CLASSES+RD_LAT+1 (9 cycles after T for the defaults).
- start dropping during ISSUE or DRAIN is ignored; the run completes. If start is already low on entering DONE, done is high for exactly one cycle.
- start high with no sequencer release simply holds DONE. The block never retriggers without passing through IDLE.
- mem_dout is ignored whenever no valid bit is at the pipe output.

Test Plan:
- Defaults, BRAM = {10, -3, 250, 7, 250, -90}, start held until done: class_id=2 (tie keeps lower index), max_val=250, done first high at T+9; mem_addr 0..5 on cycles T+1..T+6.
- All logits = -32768: class_id=0, max_val=-32768, result_valid=1.
- Max at last index, {-5,-4,-3,-2,-1,0}: class_id=5, max_val=0. This checks that the final pipelined word is not dropped.
- start pulsed 1 cycle then low: full run completes; done high exactly one cycle; back in IDLE; result held. A second start with {1,9,0,0,0,0} gives class_id=1, and result_valid goes 0 on the cycle after start until the new done.
- rst_n=0 for one cycle during ISSUE at addr 3: next cycle all outputs are at reset values and state is IDLE; a following start yields a correct, complete result.
- RD_LAT=1, N_CLASSES=1, BRAM={-7}: class_id=0, max_val=-7, done at T+3.
